// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, imem addressing and a small prefetch FIFO toward decode.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("fetch_unit: DEPTH must be a power of 2 and >= 2");
  end

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];

  logic push;
  logic pop;
  logic full;

  // Low two bits of the redirect target are dropped on purpose.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_addr = fetch_pc_q[ADDR_W+1:2];
  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !redirect && (!full || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      // The pop (if any) is honoured by decode; everything left is discarded.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // Outputs come only from stored entries; zeroed when nothing is held.
  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = instr_mem_q[rd_ptr_q];
      out_pc    = pc_mem_q[rd_ptr_q];
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model predicts every output.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 4;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]       fetch_count;
  logic [15:0]       flush_count;
`endif

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .flush_count(flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int fails     = 0;

  // Reference model: queue of {instr, pc} entries, fetch PC, perf counts, consumed log.
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [15:0] m_flush;
  logic [31:0] consumed [$];

  function automatic logic exp_valid();
    return m_q.size() != 0;
  endfunction

  function automatic logic [31:0] exp_pc();
    return (m_q.size() != 0) ? m_q[0][31:0] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr();
    return m_pc[ADDR_W+1:2];
  endfunction

  // Called at a falling edge; drives one cycle of inputs and advances the model across the edge.
  task automatic tick(input logic redir, input logic [31:0] rpc, input logic rdy);
    bit          do_pop;
    bit          do_push;
    logic [31:0] word;
    redirect    = redir;
    redirect_pc = rpc;
    out_ready   = rdy;
    do_pop  = (m_q.size() != 0) && rdy;
    do_push = !redir && ((m_q.size() < DEPTH) || do_pop);
    word    = mem[m_pc[ADDR_W+1:2]];
    if (do_pop) consumed.push_back(m_q[0][31:0]);
    @(posedge clock);
    if (do_pop) void'(m_q.pop_front());
    if (redir) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (m_flush != 16'hFFFF) m_flush++;
    end else if (do_push) begin
      m_q.push_back({word, m_pc});
      m_pc = m_pc + 32'd4;
      m_fetch++;
    end
    @(negedge clock);
  endtask

  task automatic model_reset();
    m_q.delete();
    consumed.delete();
    m_pc    = 32'h0;
    m_fetch = 32'h0;
    m_flush = 16'h0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_mem_pattern();
    for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 + k;
  endtask

  task automatic test_reset();
    load_mem_pattern();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    tests_run++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      fails++; $display("FAIL reset_out: got pc %h instr %h want 0/0", out_pc, out_instr);
    end
    tests_run++;
    if (imem_addr !== 6'd0) begin
      fails++; $display("FAIL reset_addr: got %0d want 0", imem_addr);
    end
`ifdef FETCH_PERF_EN
    tests_run++;
    if (fetch_count !== 32'h0 || flush_count !== 16'h0) begin
      fails++; $display("FAIL reset_perf: got %0d/%0d want 0/0", fetch_count, flush_count);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_stream();
    // Still before the first clock edge after release: nothing visible yet.
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL stream_pre_valid: got %b want 0", out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 32'h0, 1'b1);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'hA000_0000 + 32'(i)) begin
        fails++;
        $display("FAIL stream_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, out_valid,
                 out_pc, out_instr, 32'(4 * i), 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0);
    tests_run++;
    if (imem_addr !== 6'd4 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
      fails++;
      $display("FAIL stall_full: got addr=%0d v=%b pc=%h want addr=4 v=1 pc=0", imem_addr,
               out_valid, out_pc);
    end
    for (int i = 0; i < 5; i++) begin
      want = 32'(4 * i);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== want) begin
        fails++; $display("FAIL drain_%0d: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, want);
      end
      tick(1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0);
    tick(1'b1, 32'h0000_0043, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      fails++;
      $display("FAIL redir_bubble: got v=%b pc=%h instr=%h want 0/0/0", out_valid, out_pc, out_instr);
    end
    tick(1'b0, 32'h0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== mem[16]) begin
      fails++;
      $display("FAIL redir_target: got v=%b pc=%h instr=%h want v=1 pc=40 instr=%h", out_valid,
               out_pc, out_instr, mem[16]);
    end
    for (int i = 1; i < 4; i++) begin
      tick(1'b0, 32'h0, 1'b1);
      tests_run++;
      if (out_pc !== 32'h40 + 32'(4 * i)) begin
        fails++; $display("FAIL redir_seq_%0d: got pc=%h want %h", i, out_pc, 32'h40 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_pop();
    int          seen;
    logic [5:0]  addr_before;
    do_reset();
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    // Observed handshake at the redirect cycle, seen from the DUT side.
    redirect = 1'b1; redirect_pc = 32'h20; out_ready = 1'b1;
    seen = 0;
    if (out_valid === 1'b1 && out_pc === 32'h0) seen++;
    tick(1'b1, 32'h20, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL rp_empty: got v=%b want 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      if (out_valid === 1'b1 && out_pc === 32'h0) seen++;
      tick(1'b0, 32'h0, 1'b1);
      tests_run++;
      if (out_pc !== 32'h20 + 32'(4 * i)) begin
        fails++; $display("FAIL rp_seq_%0d: got pc=%h want %h", i, out_pc, 32'h20 + 32'(4 * i));
      end
    end
    tests_run++;
    if (seen !== 1) begin
      fails++; $display("FAIL rp_once: got %0d pops of pc 0 want 1", seen);
    end
    // Fill, then pop and push together: occupancy must stay at the limit.
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b1);
    addr_before = imem_addr;
    tick(1'b0, 32'h0, 1'b0);
    tests_run++;
    if (imem_addr !== addr_before || imem_addr !== exp_addr() || out_pc !== exp_pc()) begin
      fails++;
      $display("FAIL full_poppush: got addr=%0d pc=%h want addr=%0d pc=%h", imem_addr, out_pc,
               exp_addr(), exp_pc());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs   [4];
    logic [5:0]  addrs [4];
    pcs   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    addrs = '{6'd62, 6'd63, 6'd0, 6'd1};
    do_reset();
    tick(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (imem_addr !== addrs[i]) begin
        fails++; $display("FAIL wrap_addr_%0d: got %0d want %0d", i, imem_addr, addrs[i]);
      end
      tick(1'b0, 32'h0, 1'b1);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== mem[addrs[i]]) begin
        fails++;
        $display("FAIL wrap_out_%0d: got v=%b pc=%h instr=%h want pc=%h instr=%h", i, out_valid,
                 out_pc, out_instr, pcs[i], mem[addrs[i]]);
      end
    end
  endtask

  task automatic test_random();
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      redir = ($urandom_range(7) == 0);
      rpc   = $urandom;
      rdy   = ($urandom_range(9) < 7);
      tick(redir, rpc, rdy);
      tests_run++;
      if (out_valid !== exp_valid() || out_pc !== exp_pc() || out_instr !== exp_instr() ||
          imem_addr !== exp_addr()) begin
        fails++;
        $display("FAIL rand_%0d: got v=%b pc=%h instr=%h addr=%0d want v=%b pc=%h instr=%h addr=%0d",
                 c, out_valid, out_pc, out_instr, imem_addr, exp_valid(), exp_pc(), exp_instr(),
                 exp_addr());
      end
`ifdef FETCH_PERF_EN
      tests_run++;
      if (fetch_count !== m_fetch || flush_count !== m_flush) begin
        fails++;
        $display("FAIL rand_perf_%0d: got %0d/%0d want %0d/%0d", c, fetch_count, flush_count,
                 m_fetch, m_flush);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    load_mem_pattern();
    do_reset();
    for (int i = 0; i < 23; i++) begin
      tick((i == 5) || (i == 11) || (i == 17), 32'(i * 8), 1'b1);
    end
`ifdef FETCH_PERF_EN
    tests_run++;
    if (fetch_count !== 32'd20 || flush_count !== 16'd3) begin
      fails++; $display("FAIL perf_counts: got %0d/%0d want 20/3", fetch_count, flush_count);
    end
`endif
    tests_run++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pre_valid: got %b want 1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 6'd0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b pc=%h addr=%0d want 0/0/0", out_valid, out_pc, imem_addr);
    end
`ifdef FETCH_PERF_EN
    tests_run++;
    if (fetch_count !== 32'h0 || flush_count !== 16'h0) begin
      fails++; $display("FAIL mid_perf: got %0d/%0d want 0/0", fetch_count, flush_count);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    tick(1'b0, 32'h0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin
      fails++;
      $display("FAIL mid_restart: got v=%b pc=%h instr=%h want 1/0/A0000000", out_valid, out_pc,
               out_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
